// File: rtl/final_serializer.sv
`default_nettype none
// ============================================================================
// Module   : final_serializer
// Purpose  : Drains DEPTH-element signed frames one element per cycle over a
//            valid/ready stream; active + hold buffers give bubble-free streaming.
//            Optional FINAL_SER_PARITY_EN adds the serial_parity output.
// Revision : 1.0 - initial release
// ============================================================================
module final_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [WIDTH-1:0]      final_out [0:DEPTH-1],
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic signed [WIDTH-1:0]      serial_out,
  output logic                         serial_valid,
  input  logic                         serial_ready,
  output logic [$clog2(DEPTH)-1:0]     serial_idx,
  output logic                         serial_last
`ifdef FINAL_SER_PARITY_EN
  ,
  output logic                         serial_parity
`endif
);

  localparam int c_IW = $clog2(DEPTH);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [WIDTH-1:0] r_act      [0:DEPTH-1];
  logic signed [WIDTH-1:0] r_hold     [0:DEPTH-1];
  logic signed [WIDTH-1:0] w_act_nxt  [0:DEPTH-1];
  logic                    r_hold_full;
  logic                    w_hold_full_nxt;
  logic [c_IW-1:0]         r_idx;
  logic [c_IW-1:0]         w_idx_nxt;
  logic signed [WIDTH-1:0] r_sout;
  logic                    r_last;
  logic                    w_fire;
  logic                    w_retire;
  logic                    w_accept;
  logic                    w_act_free;
  logic                    w_hold_to_act;
  logic                    w_load_act;
  logic                    w_load_hold;

  always_comb begin
    w_fire        = (r_state == S_SHIFT) && serial_ready;
    w_retire      = w_fire && (r_idx == c_LAST);
    w_accept      = frame_valid && !r_hold_full;
    w_act_free    = (r_state == S_IDLE) || w_retire;
    w_hold_to_act = w_retire && r_hold_full;
    // accept implies hold is empty, so the active path never competes with hold_to_act
    w_load_act    = w_accept && w_act_free;
    w_load_hold   = w_accept && !w_act_free;

    w_act_nxt = r_act;
    if (w_hold_to_act)
      w_act_nxt = r_hold;
    else if (w_load_act)
      w_act_nxt = final_out;

    w_state_nxt = r_state;
    if (w_hold_to_act || w_load_act)
      w_state_nxt = S_SHIFT;
    else if (w_retire)
      w_state_nxt = S_IDLE;

    w_hold_full_nxt = r_hold_full;
    if (w_hold_to_act)
      w_hold_full_nxt = 1'b0;
    else if (w_load_hold)
      w_hold_full_nxt = 1'b1;

    w_idx_nxt = r_idx;
    if (w_fire)
      w_idx_nxt = w_retire ? '0 : r_idx + c_IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold_full <= 1'b0;
      r_idx       <= '0;
      r_sout      <= '0;
      r_last      <= 1'b0;
`ifdef FINAL_SER_PARITY_EN
      serial_parity <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_idx       <= w_idx_nxt;
      r_act       <= w_act_nxt;
      if (w_load_hold)
        r_hold <= final_out;
      // output view only moves while a frame is (or becomes) active, so stalls hold it
      if (w_state_nxt == S_SHIFT) begin
        r_sout <= w_act_nxt[w_idx_nxt];
        r_last <= (w_idx_nxt == c_LAST);
`ifdef FINAL_SER_PARITY_EN
        serial_parity <= ^w_act_nxt[w_idx_nxt];
`endif
      end else begin
        r_last <= 1'b0;
      end
    end
  end

  assign frame_ready  = !r_hold_full;
  assign serial_valid = (r_state == S_SHIFT);
  assign serial_out   = r_sout;
  assign serial_idx   = r_idx;
  assign serial_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_final_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_final_serializer
// Purpose  : Directed self-checking bench for final_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_final_serializer;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] fin [0:7];
  logic               frame_valid;
  logic               frame_ready;
  logic signed [15:0] serial_out;
  logic               serial_valid;
  logic               serial_ready;
  logic [2:0]         serial_idx;
  logic               serial_last;
`ifdef FINAL_SER_PARITY_EN
  logic               serial_parity;
`endif

  int checks   = 0;
  int failures = 0;

  final_serializer #(.WIDTH(16), .DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .final_out    (fin),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .serial_out   (serial_out),
    .serial_valid (serial_valid),
    .serial_ready (serial_ready),
    .serial_idx   (serial_idx),
    .serial_last  (serial_last)
`ifdef FINAL_SER_PARITY_EN
    ,
    .serial_parity(serial_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp(input int base);
    for (int i = 0; i < 8; i++) fin[i] = 16'(base + i);
  endtask

  initial begin
    int  k;
    int  fcnt;
    bit  acc;
    bit  hs;
    bit  stalled;
    bit  c_taken;
    logic signed [15:0] prev_out;
    logic [2:0]         prev_idx;
    int  exp_d [0:15];

    // reset with a frame offered: nothing may be taken
    rst = 1'b1; frame_valid = 1'b1; serial_ready = 1'b1; set_ramp(90);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready", frame_ready, 1);
      check("rst_valid", serial_valid, 0);
      check("rst_out", serial_out, 0);
      check("rst_idx", serial_idx, 0);
      check("rst_last", serial_last, 0);
    end
    rst = 1'b0; frame_valid = 1'b0;
    tick();
    check("post_rst_valid", serial_valid, 0);

    // single frame -8..-1
    set_ramp(-8); frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("single_valid", serial_valid, 1);
      check("single_out", serial_out, -8 + i);
      check("single_idx", serial_idx, i);
      check("single_last", serial_last, (i == 7) ? 1 : 0);
      tick();
    end
    check("single_done", serial_valid, 0);

    // back-to-back A={0..7}, B={100..107}
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin set_ramp(0); frame_valid = 1'b1; end
      else if (c == 1) set_ramp(100);
      else frame_valid = 1'b0;
      tick();
      check("b2b_valid", serial_valid, 1);
      check("b2b_out", serial_out, (c < 8) ? c : 100 + c - 8);
    end
    frame_valid = 1'b0;
    tick();
    check("b2b_done", serial_valid, 0);

    // backpressure: A active, B held, C stalled
    serial_ready = 1'b0;
    set_ramp(10); frame_valid = 1'b1;
    tick();
    check("bp_a_valid", serial_valid, 1);
    check("bp_a_out", serial_out, 10);
    check("bp_ready_after_a", frame_ready, 1);
    set_ramp(20);
    tick();
    check("bp_ready_after_b", frame_ready, 0);
    check("bp_hold_out", serial_out, 10);
    set_ramp(30);
    tick();
    tick();
    check("bp_c_stalled", frame_ready, 0);
    check("bp_stall_out", serial_out, 10);
    check("bp_stall_idx", serial_idx, 0);
    serial_ready = 1'b1;
    c_taken = 1'b0;
    for (int j = 0; j < 24; j++) begin
      check("bp_valid", serial_valid, 1);
      check("bp_out", serial_out, 10 * (j / 8 + 1) + (j % 8));
      acc = frame_valid && frame_ready;
      tick();
      if (acc) begin frame_valid = 1'b0; c_taken = 1'b1; end
    end
    check("bp_c_taken", c_taken, 1);
    check("bp_done", serial_valid, 0);

    // random ready with full-scale alternating pattern
    for (int i = 0; i < 8; i++) begin
      exp_d[i]     = (i % 2 == 0) ? 32767 : -32768;
      exp_d[i + 8] = (i % 2 == 0) ? -32768 : 32767;
    end
    for (int i = 0; i < 8; i++) fin[i] = 16'(exp_d[i]);
    frame_valid = 1'b1;
    k = 0; fcnt = 0; stalled = 1'b0; prev_out = '0; prev_idx = '0;
    for (int c = 0; c < 300 && k < 16; c++) begin
      serial_ready = 1'($urandom_range(0, 1));
      if (serial_valid) begin
        check("rnd_out", serial_out, exp_d[k]);
        if (stalled) begin
          check("rnd_stable_out", serial_out, prev_out);
          check("rnd_stable_idx", serial_idx, prev_idx);
        end
      end
      hs       = serial_valid && serial_ready;
      acc      = frame_valid && frame_ready;
      stalled  = serial_valid && !serial_ready;
      prev_out = serial_out;
      prev_idx = serial_idx;
      tick();
      if (hs) k++;
      if (acc) begin
        fcnt++;
        if (fcnt == 1) for (int i = 0; i < 8; i++) fin[i] = 16'(exp_d[i + 8]);
        else frame_valid = 1'b0;
      end
    end
    frame_valid = 1'b0;
    check("rnd_count", k, 16);
    serial_ready = 1'b1;
    tick();
    check("rnd_done", serial_valid, 0);

    // mid-frame reset with a frame waiting in hold
    fin[0] = 16'sh0007; fin[1] = 16'sh0003;
    for (int i = 2; i < 8; i++) fin[i] = 16'(i);
    frame_valid = 1'b1;
    tick();
    check("mid_out0", serial_out, 7);
`ifdef FINAL_SER_PARITY_EN
    check("parity_7", serial_parity, 1);
`endif
    set_ramp(50);
    tick();
    frame_valid = 1'b0;
    check("mid_out1", serial_out, 3);
    check("mid_hold_full", frame_ready, 0);
`ifdef FINAL_SER_PARITY_EN
    check("parity_3", serial_parity, 0);
`endif
    tick();
    tick();
    check("mid_idx3", serial_idx, 3);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", serial_valid, 0);
    check("mid_rst_out", serial_out, 0);
    check("mid_rst_idx", serial_idx, 0);
    check("mid_rst_last", serial_last, 0);
    check("mid_rst_ready", frame_ready, 1);
    rst = 1'b0;
    tick();
    check("mid_after_valid", serial_valid, 0);
    check("mid_after_out", serial_out, 0);
    tick();
    check("mid_discarded", serial_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
